// File: rtl/semaforo_pkg.sv
// Shared colour codes and FSM state encoding for the traffic-light controller.
package semaforo_pkg;
   localparam logic [1:0] ROJO     = 2'b00;
   localparam logic [1:0] AMARILLO = 2'b01;
   localparam logic [1:0] VERDE    = 2'b10;

   typedef enum logic [1:0] {
      ST_TODO_ROJO = 2'b00,
      ST_VERDE     = 2'b01,
      ST_AMARILLO  = 2'b10,
      ST_PEATON    = 2'b11
   } estado_t;
endpackage

// File: rtl/temporizador.sv
// Per-state up-counter: clears on state change, holds when disabled.
module temporizador #(
   parameter int W_T = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           enb,
   input  logic           clr,
   output logic [W_T-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (enb) cnt <= clr ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/semaforo_n_vias.sv
// Round-robin N-approach traffic light with amber, all-red clearance and a
// pedestrian all-red walk phase that can cut green short.
module semaforo_n_vias
   import semaforo_pkg::*;
#(
   parameter int N_VIAS      = 2,
   parameter int W_T         = 8,
   parameter int T_VERDE     = 8,
   parameter int T_VERDE_MIN = 3,
   parameter int T_AMARILLO  = 2,
   parameter int T_ROJO      = 1,
   parameter int T_PEATON    = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        ENB,
   input  logic [N_VIAS-1:0]           Peatonal,
   output logic [2*N_VIAS-1:0]         Semaforo,
   output logic [N_VIAS-1:0]           Cruce,
   output logic [$clog2(N_VIAS)-1:0]   Via,
   output logic [1:0]                  Estado
);
   localparam int VW = $clog2(N_VIAS);

   estado_t           estado, nxt;
   logic [W_T-1:0]    cnt;
   logic              cambio;
   logic [N_VIAS-1:0] pend, pend_nxt;

   temporizador #(.W_T(W_T)) u_tmr (
      .clk   (CLK),
      .rst_n (RST),
      .enb   (ENB),
      .clr   (cambio),
      .cnt   (cnt)
   );

   always_comb begin
      nxt = estado;
      case (estado)
         ST_TODO_ROJO: if (cnt == W_T'(T_ROJO - 1))
                          nxt = (|pend) ? ST_PEATON : ST_VERDE;
         ST_VERDE:     if (cnt == W_T'(T_VERDE - 1) ||
                           ((|pend) && cnt >= W_T'(T_VERDE_MIN - 1)))
                          nxt = ST_AMARILLO;
         ST_AMARILLO:  if (cnt == W_T'(T_AMARILLO - 1)) nxt = ST_TODO_ROJO;
         ST_PEATON:    if (cnt == W_T'(T_PEATON - 1))   nxt = ST_VERDE;
         default:      nxt = ST_TODO_ROJO;
      endcase
   end

   assign cambio = (nxt != estado);

   // Presses on approaches currently walking are dropped; set beats the exit clear.
   always_comb begin
      pend_nxt = pend;
      if (estado == ST_PEATON && cambio) pend_nxt = pend & ~Cruce;
      pend_nxt = pend_nxt | (Peatonal & ((estado == ST_PEATON) ? ~Cruce : '1));
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         estado <= ST_TODO_ROJO;
         Via    <= '0;
         pend   <= '0;
         Cruce  <= '0;
      end else if (ENB) begin
         estado <= nxt;
         pend   <= pend_nxt;
         if (estado == ST_AMARILLO && cambio)
            Via <= (Via == VW'(N_VIAS - 1)) ? '0 : Via + 1'b1;
         if (estado == ST_TODO_ROJO && nxt == ST_PEATON) Cruce <= pend;
         else if (estado == ST_PEATON && cambio)         Cruce <= '0;
      end
   end

   assign Estado = estado;

   for (genvar i = 0; i < N_VIAS; i++) begin : g_dec
      assign Semaforo[2*i +: 2] =
         (Via != VW'(i))            ? ROJO     :
         (estado == ST_VERDE)       ? VERDE    :
         (estado == ST_AMARILLO)    ? AMARILLO : ROJO;
   end
endmodule

// File: doc/semaforo_n_vias.md
# semaforo_n_vias

Parametrised traffic-light controller for an intersection of `N_VIAS` approaches. Green is granted round-robin, and every phase change passes through amber and an all-red clearance. Pedestrian requests are latched and served in a dedicated all-red walk phase; a pending request can shorten the current green. It replaces the fixed two-approach controller and is driven by the same `CLK`/`ENB`/`RST` stimulus style used in the lab testers.

## Interface
- `N_VIAS`, 2: number of approaches (≥2).
- `W_T`, 8: timer width in bits.
- `T_VERDE`, 8: full green duration, in cycles.
- `T_VERDE_MIN`, 3: minimum green before a pedestrian request may cut green short (1 ≤ `T_VERDE_MIN` ≤ `T_VERDE`).
- `T_AMARILLO`, 2: amber duration, in cycles.
- `T_ROJO`, 1: all-red clearance duration, in cycles.
- `T_PEATON`, 4: pedestrian walk duration, in cycles.
- All durations are ≥1 and < 2^`W_T`.

Ports:
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: reset, asynchronous assert, **active-low**.
- `ENB` input 1: enable; when 0, all state holds.
- `Peatonal` input `N_VIAS`: pedestrian buttons, one per approach, level-sampled.
- `Semaforo` output 2·`N_VIAS`: colour of approach i on bits [2i+1:2i]. Codes: ROJO=00, AMARILLO=01, VERDE=10; 11 is never driven.
- `Cruce` output `N_VIAS`: walk signal per approach.
- `Via` output ⌈log2 `N_VIAS`⌉: index of the approach currently owning or next receiving green.
- `Estado` output 2: FSM state, for debug.

## Operation
- **States:** TODO_ROJO=00, VERDE=01, AMARILLO=10, PEATON=11.
- **Output decode (Moore):** outputs are decoded from registered state only.
  - VERDE: `Semaforo[Via]`=VERDE.
  - AMARILLO: `Semaforo[Via]`=AMARILLO.
  - All other approaches, and all approaches in TODO_ROJO/PEATON: ROJO.
- **Reset values (RST=0):** state TODO_ROJO, `Via`=0, timer=0, `Pend`=0, `Cruce`=0. All `Semaforo` fields ROJO.
- **Timer:** counts up from 0 in each state. A state of duration T lasts exactly T enabled cycles. The timer clears on every state change.
- **Transitions** (evaluated only when `ENB`=1):
  - TODO_ROJO, timer=`T_ROJO`-1:
    - if `Pend`≠0 → PEATON, with `Cruce`←`Pend`;
    - otherwise → VERDE.
  - PEATON, timer=`T_PEATON`-1 → VERDE. On exit, `Pend`←`Pend` & ~`Cruce` and `Cruce`←0.
  - VERDE → AMARILLO when either:
    - timer=`T_VERDE`-1, or
    - `Pend`≠0 and timer ≥ `T_VERDE_MIN`-1.
  - AMARILLO, timer=`T_AMARILLO`-1 → TODO_ROJO, with `Via`←(`Via`+1) mod `N_VIAS`. Wrap-around from `N_VIAS`-1 to 0.
- **Request latching:**
  - Each enabled cycle, `Pend[i]` is set if `Peatonal[i]`=1.
  - During PEATON, a press on an approach with `Cruce[i]`=1 is ignored because it is already being served. Presses on other approaches are latched.
  - If set and clear hit the same bit in the same cycle, set wins, except for the `Cruce[i]` case above.
- **ENB=0:** state, timer, `Via`, `Pend` and `Cruce` hold, and buttons are not sampled. Outputs hold their values.
- **Mid-operation reset:** RST low forces reset values immediately, with no clock required. Any pending requests are lost.

## Timing
- Every output change is visible after the `CLK` edge that changes state; there is no additional pipeline latency.
- A button press sampled at edge k can shorten green at the earliest at edge k+1, and only once green has lasted ≥`T_VERDE_MIN` cycles.
- Full cycle with no requests: `N_VIAS`·(`T_VERDE`+`T_AMARILLO`+`T_ROJO`) cycles. With defaults this is 22.
- The same approach never sees AMARILLO→VERDE without a TODO_ROJO in between.
- RST deassertion is assumed synchronised externally. The first enabled edge after release counts as timer cycle 0 of TODO_ROJO.

## Structure
- Package `semaforo_pkg` holds the colour codes ROJO/AMARILLO/VERDE and the state encoding. The lab testers share it.
- Sub-module `temporizador` (`W_T` wide): up-counter with `clr`, `enb` and count output. The top-level compares the count against each state's duration.
- The FSM, `Pend`/`Cruce` registers and output decode live in the top-level.

## Test plan
- Reset with `ENB`=1 and no presses → ROJO/ROJO for 1 cycle, then A VERDE for 8, A AMARILLO for 2, all-red for 1, B VERDE; period 22 cycles, `Via` wraps 1→0.
- Press `Peatonal[1]` for 1 cycle at green cycle 0 of via 0 → green ends after 3 cycles, AMARILLO 2, TODO_ROJO 1, then PEATON with `Cruce`=10 for 4 cycles, then via 1 VERDE and `Pend`=0.
- Press `Peatonal[0]` during PEATON serving `Cruce`=01 → press ignored, `Pend`=0 after PEATON. Pressing `Peatonal[1]` instead → `Pend`=10 remains and shortens the next green.
- Drop `ENB` to 0 for 5 cycles mid-VERDE → `Semaforo`, timer and `Estado` frozen; remaining green after re-enable equals the remaining green before the pause.
- Assert RST low asynchronously mid-AMARILLO → all ROJO and `Via`=0 before the next edge; normal sequence restarts on release.
- `N_VIAS`=3 build → green order 0→1→2→0, with only one non-ROJO field at any time.
